// File: rtl/pass_through_pkg.sv
// Shared types for the width-adapting pass-through pipe.
package pass_through_pkg;

   typedef enum logic [1:0] {
      FM_PASS  = 2'b00,
      FM_ZEROS = 2'b01,
      FM_ONES  = 2'b10,
      FM_REPL  = 2'b11
   } fill_mode_e;

endpackage

// File: rtl/pass_through_fill.sv
// Combinational expander: widens a narrow word to WIDTH bits according to the fill mode.
module pass_through_fill
   import pass_through_pkg::*;
#(
   parameter int WIDTH      = 40,
   parameter int IN_WIDTH   = 2,
   parameter int SIGNED_EXT = 0
) (
   input  logic [IN_WIDTH-1:0] inp,
   input  fill_mode_e          mode,
   output logic [WIDTH-1:0]    out
);

   logic [WIDTH-1:0] ext;

   // Equal widths need no extension; a zero-count replication is illegal.
   generate
      if (IN_WIDTH == WIDTH) begin : g_no_ext
         assign ext = inp;
      end else begin : g_ext
         logic fill_bit;
         assign fill_bit = (SIGNED_EXT != 0) ? inp[IN_WIDTH-1] : 1'b0;
         assign ext      = {{(WIDTH-IN_WIDTH){fill_bit}}, inp};
      end
   endgenerate

   always_comb begin
      out = '0;
      case (mode)
         FM_PASS:  out = ext;
         FM_ZEROS: out = '0;
         FM_ONES:  out = '1;
         FM_REPL:  out = {WIDTH{inp[0]}};
         default:  out = '0;
      endcase
   end

endmodule

// File: rtl/pass_through_pipe.sv
// Buffered width-adapting register slice: expands narrow words at write time into a DEPTH-entry FIFO.
module pass_through_pipe
   import pass_through_pkg::*;
#(
   parameter int WIDTH      = 40,
   parameter int IN_WIDTH   = 2,
   parameter int DEPTH      = 2,
   parameter int SIGNED_EXT = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_WIDTH-1:0]          in_data,
   input  logic [1:0]                   in_mode,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH-1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic [WIDTH-1:0] fill_data;
   logic             push, pop;

   // Explicit compare keeps non-power-of-two depths wrapping correctly.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   pass_through_fill #(
      .WIDTH      (WIDTH),
      .IN_WIDTH   (IN_WIDTH),
      .SIGNED_EXT (SIGNED_EXT)
   ) u_fill (
      .inp  (in_data),
      .mode (fill_mode_e'(in_mode)),
      .out  (fill_data)
   );

   assign in_ready  = (count_q != FULL_CNT);
   assign out_valid = (count_q != '0);
   assign count     = count_q;
   // Once drained, the last popped word stays visible instead of stale storage.
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : last_q;

   always_comb begin
      push     = in_valid && in_ready;
      pop      = out_valid && out_ready;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      last_d   = last_q;
      if (push) begin
         mem_d[wr_ptr_q] = fill_data;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop) begin
         last_d   = mem_q[rd_ptr_q];
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         last_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         last_q   <= last_d;
      end
   end

endmodule
